// File: rtl/fixpoint_iter_engine.sv
// Iterative bit-level reachability engine: grows s by s | (shift(s) & mask) one step per
// clock until the state stops changing or the step bound is reached.
module fixpoint_iter_engine #(
  parameter int W        = 8,
  parameter int MAX_ITER = W,
  parameter int CW       = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  init,
  input  logic [W-1:0]  mask,
  input  logic          dir,
  input  logic          wrap,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic          timeout,
  output logic [W-1:0]  result,
  output logic [CW-1:0] iters,
  output logic [1:0]    state_dbg
);

  // Handshake: start is a request sampled only while IDLE (state_dbg == 0); the accept edge
  // captures init/mask/dir/wrap. busy marks RUN, done is a one-cycle completion pulse, and
  // result/iters/converged/timeout stay stable from done until the next accepted start.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  s;
  logic [W-1:0]  mask_q;
  logic          dir_q;
  logic          wrap_q;
  logic [W-1:0]  sh;
  logic [W-1:0]  nxt;
  logic          at_bound;

  // End bit is refilled from the opposite end only in ring mode.
  always_comb begin
    sh = '0;
    if (dir_q) sh = {wrap_q & s[0], s[W-1:1]};
    else       sh = {s[W-2:0], wrap_q & s[W-1]};
  end

  assign nxt      = s | (sh & mask_q);
  assign at_bound = (iters == CW'(MAX_ITER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      mask_q    <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      iters     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            s         <= init;
            mask_q    <= mask;
            dir_q     <= dir;
            wrap_q    <= wrap;
            iters     <= '0;
            converged <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // Convergence wins over the bound when both hold in the same cycle.
          if (nxt == s) begin
            converged <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (at_bound) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            s     <= nxt;
            iters <= iters + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign result    = s;
  assign state_dbg = state;

endmodule

// File: tb/tb_fixpoint_iter_engine.sv
// Directed bench for fixpoint_iter_engine: default instance (W=8, MAX_ITER=8) plus a
// MAX_ITER=3 instance for the timeout path.
module tb_fixpoint_iter_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start_t;
  logic [7:0] init;
  logic [7:0] mask;
  logic       dir;
  logic       wrap;

  logic       busy, done, converged, timeout;
  logic [7:0] result;
  logic [3:0] iters;
  logic [1:0] state_dbg;

  logic       busy_t, done_t, converged_t, timeout_t;
  logic [7:0] result_t;
  logic [1:0] iters_t;
  logic [1:0] state_dbg_t;

  int tests_run;
  int tests_failed;

  fixpoint_iter_engine #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init(init), .mask(mask), .dir(dir),
    .wrap(wrap), .busy(busy), .done(done), .converged(converged), .timeout(timeout),
    .result(result), .iters(iters), .state_dbg(state_dbg)
  );

  fixpoint_iter_engine #(.W(8), .MAX_ITER(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .init(init), .mask(mask), .dir(dir),
    .wrap(wrap), .busy(busy_t), .done(done_t), .converged(converged_t), .timeout(timeout_t),
    .result(result_t), .iters(iters_t), .state_dbg(state_dbg_t)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one run and returns the number of edges from the accept edge to the edge that
  // raised done (-1 if done never came within the budget).
  task automatic do_run(input bit sel, input logic [7:0] i, input logic [7:0] m,
                        input logic d, input logic wr, output int lat);
    @(posedge clk);
    @(negedge clk);
    init = i; mask = m; dir = d; wrap = wr;
    if (sel) start_t = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start_t = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if ((sel ? done_t : done) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_t = 1'b0;
    init = 8'hA5; mask = 8'hFF; dir = 1'b0; wrap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, converged, timeout, result, iters} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b conv=%b to=%b result=%h iters=%0d, want all 0",
               busy, done, converged, timeout, result, iters);
    end
    tests_run++;
    if ({busy_t, done_t, converged_t, timeout_t, result_t, iters_t} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs_t: got result=%h iters=%0d, want all 0", result_t, iters_t);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_chain();
    int lat;
    do_run(1'b0, 8'h01, 8'hFF, 1'b0, 1'b0, lat);
    tests_run++;
    if (lat !== 8) begin
      tests_failed++; $display("FAIL chain_latency: got %0d want 8", lat);
    end
    tests_run++;
    if ({result, iters, converged, timeout} !== {8'hFF, 4'd7, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL chain_result: got result=%h iters=%0d conv=%b to=%b want FF/7/1/0",
               result, iters, converged, timeout);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({done, result, iters} !== {1'b0, 8'hFF, 4'd7}) begin
      tests_failed++;
      $display("FAIL chain_hold: got done=%b result=%h iters=%0d want 0/FF/7", done, result, iters);
    end
  endtask

  task automatic test_masked();
    int lat;
    do_run(1'b0, 8'h01, 8'h0F, 1'b0, 1'b0, lat);
    tests_run++;
    if ({lat == 4, result, iters, converged} !== {1'b1, 8'h0F, 4'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL masked_msb: got lat=%0d result=%h iters=%0d conv=%b want 4/0F/3/1",
               lat, result, iters, converged);
    end
    do_run(1'b0, 8'h01, 8'h0F, 1'b1, 1'b0, lat);
    tests_run++;
    if ({lat == 1, result, iters, converged} !== {1'b1, 8'h01, 4'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL masked_lsb: got lat=%0d result=%h iters=%0d conv=%b want 1/01/0/1",
               lat, result, iters, converged);
    end
  endtask

  task automatic test_wrap();
    int lat;
    do_run(1'b0, 8'h01, 8'hFF, 1'b1, 1'b1, lat);
    tests_run++;
    if ({lat == 8, result, iters, converged} !== {1'b1, 8'hFF, 4'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_full: got lat=%0d result=%h iters=%0d conv=%b want 8/FF/7/1",
               lat, result, iters, converged);
    end
    do_run(1'b0, 8'h01, 8'h81, 1'b1, 1'b1, lat);
    tests_run++;
    if ({lat == 2, result, iters, converged} !== {1'b1, 8'h81, 4'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_81: got lat=%0d result=%h iters=%0d conv=%b want 2/81/1/1",
               lat, result, iters, converged);
    end
    // Without wrap, LSB-ward propagation from bit 0 goes nowhere.
    do_run(1'b0, 8'h01, 8'hFF, 1'b1, 1'b0, lat);
    tests_run++;
    if ({result, iters} !== {8'h01, 4'd0}) begin
      tests_failed++;
      $display("FAIL nowrap_lsb: got result=%h iters=%0d want 01/0", result, iters);
    end
  endtask

  task automatic test_trivial();
    int lat;
    do_run(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, lat);
    tests_run++;
    if ({lat == 1, result, iters, converged, timeout} !== {1'b1, 8'h00, 4'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL init_zero: got lat=%0d result=%h iters=%0d conv=%b to=%b want 1/00/0/1/0",
               lat, result, iters, converged, timeout);
    end
    do_run(1'b0, 8'h24, 8'h00, 1'b0, 1'b1, lat);
    tests_run++;
    if ({lat == 1, result, iters, converged} !== {1'b1, 8'h24, 4'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mask_zero: got lat=%0d result=%h iters=%0d conv=%b want 1/24/0/1",
               lat, result, iters, converged);
    end
  endtask

  task automatic test_timeout();
    int lat;
    do_run(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++; $display("FAIL timeout_latency: got %0d want 4", lat);
    end
    tests_run++;
    if ({result_t, iters_t, converged_t, timeout_t} !== {8'h0F, 2'd3, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL timeout_result: got result=%h iters=%0d conv=%b to=%b want 0F/3/0/1",
               result_t, iters_t, converged_t, timeout_t);
    end
    // Exactly 3 steps needed: convergence is seen at the bound and must win.
    do_run(1'b1, 8'h01, 8'h0F, 1'b0, 1'b0, lat);
    tests_run++;
    if ({lat == 4, result_t, iters_t, converged_t, timeout_t} !== {1'b1, 8'h0F, 2'd3, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL conv_at_bound: got lat=%0d result=%h iters=%0d conv=%b to=%b want 4/0F/3/1/0",
               lat, result_t, iters_t, converged_t, timeout_t);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(posedge clk);
    @(negedge clk);
    init = 8'h01; mask = 8'hFF; dir = 1'b0; wrap = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL busy_after_accept: got %b want 1", busy);
    end
    @(negedge clk);
    init = 8'h80; mask = 8'h00; dir = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    tests_run++;
    if ({lat == 8, result, iters, converged} !== {1'b1, 8'hFF, 4'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL start_in_run: got lat=%0d result=%h iters=%0d conv=%b want 8/FF/7/1",
               lat, result, iters, converged);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(posedge clk);
    @(negedge clk);
    init = 8'h01; mask = 8'hFF; dir = 1'b0; wrap = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, converged, timeout, result, iters} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got busy=%b done=%b conv=%b to=%b result=%h iters=%0d, want all 0",
               busy, done, converged, timeout, result, iters);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, result} !== {1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL no_pending_work: got busy=%b done=%b result=%h want 0/0/00", busy, done, result);
    end
    do_run(1'b0, 8'h10, 8'hF0, 1'b0, 1'b0, lat);
    tests_run++;
    if ({lat == 4, result, iters, converged} !== {1'b1, 8'hF0, 4'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL run_after_reset: got lat=%0d result=%h iters=%0d conv=%b want 4/F0/3/1",
               lat, result, iters, converged);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_full_chain();
    test_masked();
    test_wrap();
    test_trivial();
    test_timeout();
    test_start_ignored();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
